// File: rtl/fei4_rx_pkg.sv
// Shared types and constants for the FE-I4 receiver word assembler.
// Holds the default frame K-codes, the framing FSM states and a width helper.
package fei4_rx_pkg;

   localparam logic [7:0] SOF_K_DEFAULT = 8'hFC;  // K28.7
   localparam logic [7:0] EOF_K_DEFAULT = 8'hBC;  // K28.5

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } rx_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fei4_rx_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is presented on dout while not empty.
// A pop in the same cycle as a push while full frees the slot, so the push is kept.
module fei4_rx_sync_fifo #(
   parameter int DSIZE = 24,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [DSIZE-1:0] din,
   output logic [DSIZE-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [ASIZE:0]   size,
   output logic             drop
);

   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE-1:0] wr_ptr;
   logic [ASIZE-1:0] rd_ptr;
   logic             rd_ok;
   logic             wr_ok;

   assign empty = (size == '0);
   assign full  = (size == (ASIZE+1)'(DEPTH));
   assign rd_ok = pop & ~empty;
   assign wr_ok = push & (~full | rd_ok);
   assign drop  = push & full & ~rd_ok;
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         size   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         size <= size + (ASIZE+1)'(wr_ok) - (ASIZE+1)'(rd_ok);
      end
   end

   // Storage carries no reset; dout is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fei4_rx_word_assembler.sv
// Packs decoded 8b10b data bytes into words (first byte in the MSBs), with optional
// SOF/EOF framing, error aborts, saturating error counters and a show-ahead word FIFO.
module fei4_rx_word_assembler
   import fei4_rx_pkg::*;
#(
   parameter int         BYTES_PER_WORD = 3,
   parameter int         FIFO_ASIZE     = 4,
   parameter int         CNT_WIDTH      = 8,
   parameter logic [7:0] SOF_K          = SOF_K_DEFAULT,
   parameter logic [7:0] EOF_K          = EOF_K_DEFAULT
) (
   input  logic                        WCLK,
   input  logic                        RESET,
   input  logic                        ENABLE,
   input  logic                        FRAME_MODE,
   input  logic                        SYM_VALID,
   input  logic                        SYM_K,
   input  logic [7:0]                  SYM_DATA,
   input  logic                        SYM_ERR,
   input  logic                        READ,
   output logic [8*BYTES_PER_WORD-1:0] DATA_OUT,
   output logic                        EMPTY,
   output logic                        FULL,
   output logic [FIFO_ASIZE:0]         FIFO_SIZE,
   output logic [CNT_WIDTH-1:0]        LOST_ERR_CNT,
   output logic [CNT_WIDTH-1:0]        DECODER_ERR_CNT,
   output logic [CNT_WIDTH-1:0]        FRAME_ERR_CNT
);

   localparam int DW    = 8 * BYTES_PER_WORD;
   localparam int IDX_W = (clog2(BYTES_PER_WORD) < 1) ? 1 : clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   rx_state_t        state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             store;
   logic             push_nxt;
   logic             push;
   logic             dec_inc;
   logic             frm_inc;
   logic             drop;
   logic [DW-1:0]    asm_word;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
      return (en && (c != '1)) ? c + 1'b1 : c;
   endfunction

   always_ff @(posedge WCLK or posedge RESET) begin
      if (RESET) begin
         state           <= IDLE;
         idx             <= '0;
         push            <= 1'b0;
         LOST_ERR_CNT    <= '0;
         DECODER_ERR_CNT <= '0;
         FRAME_ERR_CNT   <= '0;
      end else begin
         state           <= state_nxt;
         idx             <= idx_nxt;
         push            <= push_nxt;
         LOST_ERR_CNT    <= sat_inc(LOST_ERR_CNT, drop);
         DECODER_ERR_CNT <= sat_inc(DECODER_ERR_CNT, dec_inc);
         FRAME_ERR_CNT   <= sat_inc(FRAME_ERR_CNT, frm_inc);
      end
   end

   // Priority per accepted symbol: decoder error, then K-code, then data byte.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      store     = 1'b0;
      push_nxt  = 1'b0;
      dec_inc   = 1'b0;
      frm_inc   = 1'b0;
      if (!ENABLE) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else if (SYM_VALID) begin
         if (SYM_ERR) begin
            dec_inc   = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
         end else if (SYM_K) begin
            idx_nxt = '0;
            if (SYM_DATA == SOF_K) begin
               frm_inc   = (idx != '0) || (state == IN_FRAME);
               state_nxt = FRAME_MODE ? IN_FRAME : IDLE;
            end else if (SYM_DATA == EOF_K) begin
               frm_inc   = (idx != '0) || ((state == IDLE) && FRAME_MODE);
               state_nxt = IDLE;
            end else begin
               frm_inc = (idx != '0);
            end
         end else if (!FRAME_MODE || (state == IN_FRAME)) begin
            store = 1'b1;
            if (idx == LAST_IDX) begin
               idx_nxt  = '0;
               push_nxt = 1'b1;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end else begin
            frm_inc = 1'b1;
         end
      end
   end

   // The completed word sits here for one cycle while the FIFO writes it.
   always_ff @(posedge WCLK) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
         if (store && (idx == IDX_W'(b))) asm_word[(BYTES_PER_WORD-1-b)*8 +: 8] <= SYM_DATA;
      end
   end

   fei4_rx_sync_fifo #(
      .DSIZE(DW),
      .ASIZE(FIFO_ASIZE)
   ) u_fifo (
      .clk  (WCLK),
      .rst  (RESET),
      .push (push),
      .pop  (READ),
      .din  (asm_word),
      .dout (DATA_OUT),
      .empty(EMPTY),
      .full (FULL),
      .size (FIFO_SIZE),
      .drop (drop)
   );

endmodule

// File: tb/tb_fei4_rx_word_assembler.sv
// Directed bench for the word assembler: a symbol table with per-step expectations,
// followed by hand-written sequences for FIFO overflow, enable drop, saturation and reset.
module tb_fei4_rx_word_assembler;

   localparam logic [7:0] SOF   = 8'hFC;
   localparam logic [7:0] EOF   = 8'hBC;
   localparam logic [7:0] COMMA = 8'h3C;

   logic        WCLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ENABLE = 1'b1;
   logic        FRAME_MODE = 1'b0;
   logic        SYM_VALID = 1'b0;
   logic        SYM_K = 1'b0;
   logic [7:0]  SYM_DATA = 8'h00;
   logic        SYM_ERR = 1'b0;
   logic        READ = 1'b0;
   logic [23:0] DATA_OUT;
   logic        EMPTY;
   logic        FULL;
   logic [4:0]  FIFO_SIZE;
   logic [7:0]  LOST_ERR_CNT;
   logic [7:0]  DECODER_ERR_CNT;
   logic [7:0]  FRAME_ERR_CNT;

   int errors = 0;
   int checks = 0;

   fei4_rx_word_assembler dut (
      .WCLK           (WCLK),
      .RESET          (RESET),
      .ENABLE         (ENABLE),
      .FRAME_MODE     (FRAME_MODE),
      .SYM_VALID      (SYM_VALID),
      .SYM_K          (SYM_K),
      .SYM_DATA       (SYM_DATA),
      .SYM_ERR        (SYM_ERR),
      .READ           (READ),
      .DATA_OUT       (DATA_OUT),
      .EMPTY          (EMPTY),
      .FULL           (FULL),
      .FIFO_SIZE      (FIFO_SIZE),
      .LOST_ERR_CNT   (LOST_ERR_CNT),
      .DECODER_ERR_CNT(DECODER_ERR_CNT),
      .FRAME_ERR_CNT  (FRAME_ERR_CNT)
   );

   always #5 WCLK = ~WCLK;

   typedef struct {
      logic       k;
      logic [7:0] d;
      logic       e;
      logic       fm;
      int         size;
      int         frm;
      int         dec;
   } vec_t;

   vec_t        tbl[$];
   logic [23:0] words[$];

   function automatic vec_t v(input logic k, input logic [7:0] d, input logic e,
                              input logic fm, input int size, input int frm, input int dec);
      vec_t r;
      r.k = k; r.d = d; r.e = e; r.fm = fm; r.size = size; r.frm = frm; r.dec = dec;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic k, input logic [7:0] d, input logic e, input logic fm);
      SYM_VALID = 1'b1; SYM_K = k; SYM_DATA = d; SYM_ERR = e; FRAME_MODE = fm;
      @(posedge WCLK); #1;
      SYM_VALID = 1'b0; SYM_K = 1'b0; SYM_ERR = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge WCLK); #1;
      end
   endtask

   task automatic pop();
      READ = 1'b1;
      @(posedge WCLK); #1;
      READ = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      idle(2);
      RESET = 1'b0;
      idle(1);
   endtask

   initial begin
      // table: k, data, err, frame_mode, expected size/frame_err/decoder_err after the edge
      tbl.push_back(v(0, 8'h11, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 8'h22, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 8'h33, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 8'h44, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 8'h55, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 8'h66, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, SOF,   0, 1, 2, 0, 0));
      tbl.push_back(v(0, 8'hAA, 0, 1, 2, 0, 0));
      tbl.push_back(v(0, 8'hBB, 0, 1, 2, 0, 0));
      tbl.push_back(v(0, 8'hCC, 0, 1, 2, 0, 0));
      tbl.push_back(v(1, EOF,   0, 1, 3, 0, 0));
      tbl.push_back(v(0, 8'hDD, 0, 1, 3, 1, 0));
      tbl.push_back(v(0, 8'h01, 0, 0, 3, 1, 0));
      tbl.push_back(v(0, 8'h02, 0, 0, 3, 1, 0));
      tbl.push_back(v(1, COMMA, 0, 0, 3, 2, 0));
      tbl.push_back(v(0, 8'h03, 0, 0, 3, 2, 0));
      tbl.push_back(v(0, 8'h04, 0, 0, 3, 2, 0));
      tbl.push_back(v(0, 8'h05, 0, 0, 3, 2, 0));
      tbl.push_back(v(0, 8'h01, 0, 0, 4, 2, 0));
      tbl.push_back(v(0, 8'h02, 1, 0, 4, 2, 1));
      tbl.push_back(v(0, 8'h03, 0, 0, 4, 2, 1));
      tbl.push_back(v(0, 8'h04, 0, 0, 4, 2, 1));
      tbl.push_back(v(0, 8'h05, 0, 0, 4, 2, 1));
      tbl.push_back(v(1, COMMA, 0, 0, 5, 2, 1));
      tbl.push_back(v(1, SOF,   0, 1, 5, 2, 1));
      tbl.push_back(v(0, 8'h77, 0, 1, 5, 2, 1));
      tbl.push_back(v(1, SOF,   0, 1, 5, 3, 1));
      tbl.push_back(v(1, EOF,   0, 1, 5, 3, 1));
      tbl.push_back(v(1, EOF,   0, 1, 5, 4, 1));
      words.push_back(24'h112233);
      words.push_back(24'h445566);
      words.push_back(24'hAABBCC);
      words.push_back(24'h030405);
      words.push_back(24'h030405);

      idle(2);
      RESET = 1'b0;
      idle(1);
      check("reset_empty", 32'(EMPTY), 1);
      check("reset_full", 32'(FULL), 0);
      check("reset_size", 32'(FIFO_SIZE), 0);
      check("reset_data", 32'(DATA_OUT), 0);
      check("reset_lost", 32'(LOST_ERR_CNT), 0);
      check("reset_dec", 32'(DECODER_ERR_CNT), 0);
      check("reset_frm", 32'(FRAME_ERR_CNT), 0);

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].k, tbl[i].d, tbl[i].e, tbl[i].fm);
         check($sformatf("tbl%0d_size", i), 32'(FIFO_SIZE), 32'(tbl[i].size));
         check($sformatf("tbl%0d_frm", i), 32'(FRAME_ERR_CNT), 32'(tbl[i].frm));
         check($sformatf("tbl%0d_dec", i), 32'(DECODER_ERR_CNT), 32'(tbl[i].dec));
      end
      check("tbl_lost", 32'(LOST_ERR_CNT), 0);

      for (int i = 0; i < words.size(); i++) begin
         check($sformatf("word%0d", i), 32'(DATA_OUT), 32'(words[i]));
         pop();
      end
      check("drained_empty", 32'(EMPTY), 1);
      pop();
      check("read_empty_size", 32'(FIFO_SIZE), 0);
      check("read_empty_flag", 32'(EMPTY), 1);

      // overflow: 17 words into a 16-deep FIFO, then a push coinciding with a pop
      do_reset();
      FRAME_MODE = 1'b0;
      for (int w = 1; w <= 17; w++) begin
         for (int b = 0; b < 3; b++) send(0, 8'(w), 0, 0);
      end
      idle(1);
      check("ovf_full", 32'(FULL), 1);
      check("ovf_size", 32'(FIFO_SIZE), 16);
      check("ovf_lost", 32'(LOST_ERR_CNT), 1);
      check("ovf_head", 32'(DATA_OUT), 32'h010101);
      for (int b = 0; b < 3; b++) send(0, 8'hAA, 0, 0);
      pop();
      check("pushpop_size", 32'(FIFO_SIZE), 16);
      check("pushpop_lost", 32'(LOST_ERR_CNT), 1);
      check("pushpop_full", 32'(FULL), 1);
      for (int w = 2; w <= 16; w++) begin
         check($sformatf("ovf_word%0d", w), 32'(DATA_OUT), 32'({3{8'(w)}}));
         pop();
      end
      check("ovf_last", 32'(DATA_OUT), 32'hAAAAAA);
      pop();
      check("ovf_drained", 32'(EMPTY), 1);

      // enable dropped mid-word: partial discarded silently, strobe ignored
      send(0, 8'h01, 0, 0);
      send(0, 8'h02, 0, 0);
      ENABLE = 1'b0;
      send(0, 8'h55, 0, 0);
      ENABLE = 1'b1;
      send(0, 8'h03, 0, 0);
      send(0, 8'h04, 0, 0);
      send(0, 8'h05, 0, 0);
      idle(1);
      check("en_size", 32'(FIFO_SIZE), 1);
      check("en_word", 32'(DATA_OUT), 32'h030405);
      check("en_frm", 32'(FRAME_ERR_CNT), 0);
      pop();

      // decoder error counter saturation, then reset in the middle of a word
      for (int i = 0; i < 300; i++) send(0, 8'h00, 1, 0);
      check("dec_sat", 32'(DECODER_ERR_CNT), 32'hFF);
      send(0, 8'h0A, 0, 0);
      send(0, 8'h0B, 0, 0);
      send(0, 8'h0C, 0, 0);
      idle(1);
      check("pre_reset_size", 32'(FIFO_SIZE), 1);
      send(0, 8'h01, 0, 0);
      send(0, 8'h02, 0, 0);
      RESET = 1'b1;
      #2;
      check("async_reset_empty", 32'(EMPTY), 1);
      idle(1);
      RESET = 1'b0;
      idle(1);
      check("rst_dec", 32'(DECODER_ERR_CNT), 0);
      check("rst_lost", 32'(LOST_ERR_CNT), 0);
      check("rst_frm", 32'(FRAME_ERR_CNT), 0);
      check("rst_empty", 32'(EMPTY), 1);
      check("rst_size", 32'(FIFO_SIZE), 0);
      send(0, 8'h07, 0, 0);
      send(0, 8'h08, 0, 0);
      send(0, 8'h09, 0, 0);
      idle(1);
      check("post_rst_word", 32'(DATA_OUT), 32'h070809);
      check("post_rst_size", 32'(FIFO_SIZE), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
